// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch unit (request -> capture -> handoff -> next PC).
// Optional completed-handoff counter enabled by defining IFU_FETCH_CNT_EN.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        valid_out_idu,
  input  logic        ready_in_idu,
  output logic [31:0] pc,
  output logic [31:0] inst,
  input  logic        pc_upd_valid,
  input  logic [31:0] pc_upd,
  output logic [31:0] fetch_cnt
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH      = 2'b00,
    WAIT_MEM   = 2'b01,
    WAIT_READY = 2'b10,
    WAIT_PC    = 2'b11
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] pc_r;
  logic [31:0] pc_next_s;
  logic [31:0] inst_r;
  logic [31:0] inst_next_s;

  // Next-state and datapath update selection
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    inst_next_s  = inst_r;
    case (state_r)
      FETCH: begin
        if (mem_req_ready) begin
          state_next_s = WAIT_MEM;
        end else begin
          state_next_s = FETCH;
        end
      end
      WAIT_MEM: begin
        if (mem_resp_valid) begin
          state_next_s = WAIT_READY;
          inst_next_s  = mem_rdata;
        end else begin
          state_next_s = WAIT_MEM;
        end
      end
      WAIT_READY: begin
        if (ready_in_idu) begin
          state_next_s = WAIT_PC;
        end else begin
          state_next_s = WAIT_READY;
        end
      end
      WAIT_PC: begin
        // Instruction fetches are word aligned; drop the low address bits.
        if (pc_upd_valid) begin
          state_next_s = FETCH;
          pc_next_s    = {pc_upd[31:2], 2'b00};
        end else begin
          state_next_s = WAIT_PC;
        end
      end
      default: begin
        state_next_s = FETCH;
      end
    endcase
  end

  // State, PC and instruction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FETCH;
      pc_r    <= RESET_PC;
      inst_r  <= NOP_INST;
    end else begin
      state_r <= state_next_s;
      pc_r    <= pc_next_s;
      inst_r  <= inst_next_s;
    end
  end

  // Handshake strobes are gated by rst so nothing leaks out during reset.
  assign mem_req_valid = (state_r == FETCH) && !rst;
  assign valid_out_idu = (state_r == WAIT_READY) && !rst;
  assign mem_addr      = pc_r;
  assign pc            = pc_r;
  assign inst          = inst_r;

`ifdef IFU_FETCH_CNT_EN
  logic        handoff_s;
  logic [31:0] fetch_cnt_r;

  assign handoff_s = valid_out_idu && ready_in_idu;

  // Completed-handoff counter, wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_r <= 32'h0000_0000;
    end else if (handoff_s) begin
      fetch_cnt_r <= fetch_cnt_r + 32'h0000_0001;
    end else begin
      fetch_cnt_r <= fetch_cnt_r;
    end
  end

  assign fetch_cnt = fetch_cnt_r;
`else
  assign fetch_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed vector table, hand-written corner sequences and a
// randomized run against a transaction-level reference model of ifu_fetch.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        valid_out_idu;
  logic        ready_in_idu;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        pc_upd_valid;
  logic [31:0] pc_upd;
  logic [31:0] fetch_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .valid_out_idu(valid_out_idu), .ready_in_idu(ready_in_idu),
    .pc(pc), .inst(inst),
    .pc_upd_valid(pc_upd_valid), .pc_upd(pc_upd),
    .fetch_cnt(fetch_cnt)
  );

  typedef struct {
    logic        rst, rdy, rv;
    logic [31:0] rdata;
    logic        ri, uv;
    logic [31:0] upd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vo;
    logic [31:0] e_pc, e_inst, e_cnt;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input logic r, input logic rr, input logic rv, input logic [31:0] rd,
                              input logic ri, input logic uv, input logic [31:0] up,
                              input logic e_req, input logic [31:0] e_addr, input logic e_vo,
                              input logic [31:0] e_pc, input logic [31:0] e_inst,
                              input logic [31:0] e_cnt);
    vec_t v;
    v.rst = r; v.rdy = rr; v.rv = rv; v.rdata = rd; v.ri = ri; v.uv = uv; v.upd = up;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vo = e_vo; v.e_pc = e_pc; v.e_inst = e_inst;
    v.e_cnt = e_cnt;
    return v;
  endfunction

  // The counter only exists when the feature macro is defined.
  function automatic logic [31:0] cnt_view(input logic [31:0] c);
`ifdef IFU_FETCH_CNT_EN
    return c;
`else
    return 32'h0000_0000;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_vo, input logic [31:0] e_pc, input logic [31:0] e_inst,
                           input logic [31:0] e_cnt);
    chk({tag, ".mem_req_valid"}, {31'd0, mem_req_valid}, {31'd0, e_req});
    chk({tag, ".mem_addr"}, mem_addr, e_addr);
    chk({tag, ".valid_out_idu"}, {31'd0, valid_out_idu}, {31'd0, e_vo});
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".inst"}, inst, e_inst);
    chk({tag, ".fetch_cnt"}, fetch_cnt, cnt_view(e_cnt));
  endtask

  // Apply one cycle of inputs at the falling edge and settle before sampling.
  task automatic drive(input logic r, input logic rr, input logic rv, input logic [31:0] rd,
                       input logic ri, input logic uv, input logic [31:0] up);
    @(negedge clk);
    rst = r; mem_req_ready = rr; mem_resp_valid = rv; mem_rdata = rd;
    ready_in_idu = ri; pc_upd_valid = uv; pc_upd = up;
    #1;
  endtask

  // Reference model: the fetch unit as a transaction with three phase flags.
  logic [31:0] m_pc, m_inst, m_cnt;
  bit          m_outstanding, m_presenting, m_need_pc;

  initial begin
    logic [31:0] a, b, i1, i2;
    logic        r, rr, rv, ri, uv;
    logic [31:0] rd, up;
    a = RST_PC; b = 32'h8000_0104; i1 = 32'h0010_0093; i2 = 32'h0020_0113;

    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,          1'b0, a, 1'b0, a, NOP, 32'd0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,          1'b1, a, 1'b0, a, NOP, 32'd0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,          1'b0, a, 1'b0, a, NOP, 32'd0);
    tbl[3]  = tbl[2];
    tbl[4]  = tbl[2];
    tbl[5]  = mk(1'b0, 1'b0, 1'b1, i1,    1'b0, 1'b0, 32'h0,          1'b0, a, 1'b0, a, NOP, 32'd0);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1234_5678,  1'b0, a, 1'b1, a, i1, 32'd0);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,          1'b0, a, 1'b1, a, i1, 32'd0);
    tbl[8]  = tbl[7];
    tbl[9]  = tbl[7];
    tbl[10] = tbl[7];
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,          1'b0, a, 1'b1, a, i1, 32'd0);
    tbl[12] = mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,          1'b0, a, 1'b0, a, i1, 32'd1);
    tbl[13] = mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0106,  1'b0, a, 1'b0, a, i1, 32'd1);
    tbl[14] = mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,          1'b1, b, 1'b0, b, i1, 32'd1);
    tbl[15] = mk(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,  1'b1, b, 1'b0, b, i1, 32'd1);
    tbl[16] = mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,          1'b0, b, 1'b0, b, i1, 32'd1);
    tbl[17] = mk(1'b0, 1'b0, 1'b1, i2,    1'b0, 1'b0, 32'h0,          1'b0, b, 1'b0, b, i1, 32'd1);
    tbl[18] = mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,          1'b0, b, 1'b1, b, i2, 32'd1);

    // Initial reset so the table starts from a known state.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    for (int k = 0; k < 19; k++) begin
      drive(tbl[k].rst, tbl[k].rdy, tbl[k].rv, tbl[k].rdata, tbl[k].ri, tbl[k].uv, tbl[k].upd);
      check_out($sformatf("vec%0d", k), tbl[k].e_req, tbl[k].e_addr, tbl[k].e_vo,
                tbl[k].e_pc, tbl[k].e_inst, tbl[k].e_cnt);
    end

    // Reset during WAIT_MEM abandons the request; the late response is ignored.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0203);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_out("rstmem.req", 1'b1, 32'h8000_0200, 1'b0, 32'h8000_0200, i2, 32'd2);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("rstmem.in_rst_req", {31'd0, mem_req_valid}, 32'd0);
    chk("rstmem.in_rst_vo", {31'd0, valid_out_idu}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0);
    check_out("rstmem.after", 1'b1, a, 1'b0, a, NOP, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_out("rstmem.dropped", 1'b1, a, 1'b0, a, NOP, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 32'h0030_0193, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_out("rstmem.refetch", 1'b0, a, 1'b1, a, 32'h0030_0193, 32'd0);

    // Counter wrap: preload all-ones, one handoff must give zero.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
`ifdef IFU_FETCH_CNT_EN
    force dut.fetch_cnt_r = 32'hFFFF_FFFF;
    #1;
    chk("wrap.preload", fetch_cnt, 32'hFFFF_FFFF);
    release dut.fetch_cnt_r;
`endif
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("wrap.after", fetch_cnt, 32'h0000_0000);
    chk("wrap.vo", {31'd0, valid_out_idu}, 32'd0);

    // Randomized run against the reference model.
    m_pc = RST_PC; m_inst = NOP; m_cnt = 32'd0;
    m_outstanding = 1'b0; m_presenting = 1'b0; m_need_pc = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int n = 0; n < 600; n++) begin
      r  = ($urandom_range(0, 49) == 0);
      rr = $urandom_range(0, 1) == 1;
      rv = $urandom_range(0, 2) == 0;
      rd = $urandom;
      ri = $urandom_range(0, 2) != 0;
      uv = $urandom_range(0, 1) == 1;
      up = $urandom;
      drive(r, rr, rv, rd, ri, uv, up);
      check_out($sformatf("rnd%0d", n),
                !r && !m_outstanding && !m_presenting && !m_need_pc,
                m_pc, !r && m_presenting, m_pc, m_inst, m_cnt);
      if (r) begin
        m_pc = RST_PC; m_inst = NOP; m_cnt = 32'd0;
        m_outstanding = 1'b0; m_presenting = 1'b0; m_need_pc = 1'b0;
      end else if (m_outstanding) begin
        if (rv) begin
          m_inst = rd; m_outstanding = 1'b0; m_presenting = 1'b1;
        end
      end else if (m_presenting) begin
        if (ri) begin
          m_cnt = m_cnt + 32'd1; m_presenting = 1'b0; m_need_pc = 1'b1;
        end
      end else if (m_need_pc) begin
        if (uv) begin
          m_pc = up & 32'hFFFF_FFFC; m_need_pc = 1'b0;
        end
      end else if (rr) begin
        m_outstanding = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
